context_n_scheduler: RTL and testbench

CONTEXT_N_SCHEDULER -- requirements
Module: context_n_scheduler

---
 rtl/context_n_scheduler_pkg.sv | 19 +
 rtl/context_n_scheduler_ram.sv | 36 +++
 rtl/context_n_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_context_n_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/context_n_scheduler_pkg.sv
// Shared parameters and FSM encoding for the context N scheduler.
//   N_LENGTH_DEF  : width of a stored occurrence count N
//   CTX_COUNT_DEF : regular contexts 0..364 plus run contexts 365..366
//   CTX_W_DEF     : width of a context index
//   THRESHOLD_DEF : value of N at which the count is halved
//   state_e       : scheduler FSM states
package context_n_scheduler_pkg;

  localparam int N_LENGTH_DEF  = 7;
  localparam int CTX_COUNT_DEF = 367;
  localparam int CTX_W_DEF     = 9;
  localparam int THRESHOLD_DEF = 64;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/context_n_scheduler_ram.sv
// N table storage: DEPTH x WIDTH, one synchronous read port and one
// synchronous write port. A same-address read and write in one cycle
// returns the old contents (read-before-write); the caller forwards.
//   clk   : clock
//   re    : read enable, rdata updates on the next rising edge
//   raddr : read address
//   rdata : registered read data
//   we    : write enable
//   waddr : write address
//   wdata : write data
module context_n_ram #(
  parameter int DEPTH = 367,
  parameter int WIDTH = 7,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Non-blocking assignments give read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/context_n_scheduler.sv
// Context N scheduler: initialises every context count to 1, then for each
// accepted update request reads N, applies the increment/halving rule,
// writes the result back and reports old/new N one cycle later.
// Handshake: a request transfers when in_valid && in_ready. in_ready is high
// only in RUN with flush low. Results have no backpressure: out_valid is a
// single-cycle strobe, and out_* hold their last values while it is low.
//   clk, rst_n     : clock, synchronous active-low reset
//   flush          : restart table initialisation (new image)
//   in_valid/ready : request handshake, in_ctx = context to update
//   out_valid      : result strobe with out_ctx, out_N, out_N_new,
//                    out_reset_flag (halving occurred)
//   init_done      : high while in RUN (exposes FSM state)
//   err_ctx        : sticky, set by an out-of-range in_ctx
module context_n_scheduler
  import context_n_scheduler_pkg::*;
#(
  parameter int N_length  = N_LENGTH_DEF,
  parameter int CTX_COUNT = CTX_COUNT_DEF,
  parameter int CTX_W     = CTX_W_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CTX_W-1:0]    in_ctx,
  output logic                out_valid,
  output logic [CTX_W-1:0]    out_ctx,
  output logic [N_length-1:0] out_N,
  output logic [N_length-1:0] out_N_new,
  output logic                out_reset_flag,
  output logic                init_done,
  output logic                err_ctx
);

  state_e               state_q, state_d;
  logic [CTX_W-1:0]     init_cnt_q, init_cnt_d;
  logic                 s1_valid_q, s1_valid_d;
  logic [CTX_W-1:0]     s1_ctx_q, s1_ctx_d;
  logic                 fwd_valid_q, fwd_valid_d;
  logic [CTX_W-1:0]     fwd_ctx_q, fwd_ctx_d;
  logic [N_length-1:0]  fwd_n_q, fwd_n_d;
  logic                 err_q, err_d;
  logic [CTX_W-1:0]     hold_ctx_q, hold_ctx_d;
  logic [N_length-1:0]  hold_n_q, hold_n_d;
  logic [N_length-1:0]  hold_n_new_q, hold_n_new_d;
  logic                 hold_flag_q, hold_flag_d;

  logic                 accept, in_range, launch;
  logic [N_length-1:0]  ram_rdata, n_cur, n_new;
  logic                 halve;
  logic                 ram_we;
  logic [CTX_W-1:0]     ram_waddr;
  logic [N_length-1:0]  ram_wdata;
  logic                 s1_write;

  assign in_ready = (state_q == ST_RUN) && !flush;
  assign accept   = in_valid && in_ready;
  assign in_range = (int'(in_ctx) < CTX_COUNT);
  assign launch   = accept && in_range;

  // The previous cycle's write-back lands on the same edge as this
  // request's RAM read, so the RAM returns stale data; take the
  // forwarded value instead.
  assign n_cur = (fwd_valid_q && (fwd_ctx_q == s1_ctx_q)) ? fwd_n_q : ram_rdata;
  assign halve = (n_cur == N_length'(THRESHOLD));
  assign n_new = halve ? ((n_cur >> 1) + N_length'(1)) : (n_cur + N_length'(1));

  // A result in flight during flush is still reported but not written.
  assign s1_write = (state_q == ST_RUN) && s1_valid_q && !flush;

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = s1_ctx_q;
    ram_wdata = n_new;
    if ((state_q == ST_INIT) && !flush) begin
      ram_we    = 1'b1;
      ram_waddr = init_cnt_q;
      ram_wdata = N_length'(1);
    end else if (s1_write) begin
      ram_we = 1'b1;
    end
  end

  context_n_ram #(
    .DEPTH (CTX_COUNT),
    .WIDTH (N_length),
    .AW    (CTX_W)
  ) u_ram (
    .clk   (clk),
    .re    (launch),
    .raddr (in_ctx),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata)
  );

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    s1_valid_d   = 1'b0;
    s1_ctx_d     = s1_ctx_q;
    err_d        = err_q;
    fwd_valid_d  = s1_write;
    fwd_ctx_d    = s1_ctx_q;
    fwd_n_d      = n_new;
    hold_ctx_d   = hold_ctx_q;
    hold_n_d     = hold_n_q;
    hold_n_new_d = hold_n_new_q;
    hold_flag_d  = hold_flag_q;

    if (s1_valid_q) begin
      hold_ctx_d   = s1_ctx_q;
      hold_n_d     = n_cur;
      hold_n_new_d = n_new;
      hold_flag_d  = halve;
    end

    if (flush) begin
      state_d    = ST_INIT;
      init_cnt_d = '0;
      err_d      = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == CTX_W'(CTX_COUNT - 1)) begin
            state_d    = ST_RUN;
            init_cnt_d = '0;
          end else begin
            init_cnt_d = init_cnt_q + CTX_W'(1);
          end
        end
        ST_RUN: begin
          s1_valid_d = launch;
          if (launch) s1_ctx_d = in_ctx;
          if (accept && !in_range) err_d = 1'b1;
        end
        default: begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_ctx_q     <= '0;
      fwd_valid_q  <= 1'b0;
      fwd_ctx_q    <= '0;
      fwd_n_q      <= '0;
      err_q        <= 1'b0;
      hold_ctx_q   <= '0;
      hold_n_q     <= '0;
      hold_n_new_q <= '0;
      hold_flag_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      s1_valid_q   <= s1_valid_d;
      s1_ctx_q     <= s1_ctx_d;
      fwd_valid_q  <= fwd_valid_d;
      fwd_ctx_q    <= fwd_ctx_d;
      fwd_n_q      <= fwd_n_d;
      err_q        <= err_d;
      hold_ctx_q   <= hold_ctx_d;
      hold_n_q     <= hold_n_d;
      hold_n_new_q <= hold_n_new_d;
      hold_flag_q  <= hold_flag_d;
    end
  end

  assign out_valid      = s1_valid_q;
  assign out_ctx        = s1_valid_q ? s1_ctx_q : hold_ctx_q;
  assign out_N          = s1_valid_q ? n_cur    : hold_n_q;
  assign out_N_new      = s1_valid_q ? n_new    : hold_n_new_q;
  assign out_reset_flag = s1_valid_q ? halve    : hold_flag_q;
  assign init_done      = (state_q == ST_RUN);
  assign err_ctx        = err_q;

endmodule

// File: tb/tb_context_n_scheduler.sv
// Directed bench for context_n_scheduler: init length, increment/halving,
// back-to-back forwarding, out-of-range requests, flush and mid-INIT reset.
module tb_context_n_scheduler;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_ctx;
  logic       out_valid;
  logic [8:0] out_ctx;
  logic [6:0] out_N;
  logic [6:0] out_N_new;
  logic       out_reset_flag;
  logic       init_done;
  logic       err_ctx;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  context_n_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_ctx         (in_ctx),
    .out_valid      (out_valid),
    .out_ctx        (out_ctx),
    .out_N          (out_N),
    .out_N_new      (out_N_new),
    .out_reset_flag (out_reset_flag),
    .init_done      (init_done),
    .err_ctx        (err_ctx)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] ctx);
    in_valid = 1'b1;
    in_ctx   = ctx;
    step();
    in_valid = 1'b0;
  endtask

  // Counts cycles with in_ready low, starting with the current one.
  task automatic count_init(output int n);
    n = 0;
    while (!in_ready && n < 2000) begin
      n++;
      step();
    end
  endtask

  int n;
  logic [31:0] e;

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_ctx   = '0;
    repeat (3) step();

    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_err", err_ctx, 0);
    check("rst_out_N", out_N, 0);
    check("rst_out_N_new", out_N_new, 0);
    check("rst_out_ctx", out_ctx, 0);
    check("rst_flag", out_reset_flag, 0);

    // Init length
    rst_n = 1'b1;
    count_init(n);
    check("init_len", n, 367);
    check("init_done", init_done, 1);
    check("run_in_ready", in_ready, 1);

    // 64 spaced updates to ctx 5
    for (int i = 1; i <= 64; i++) begin
      send(9'd5);
      check("c5_valid", out_valid, 1);
      check("c5_ctx", out_ctx, 5);
      check("c5_N", out_N, i);
      check("c5_N_new", out_N_new, (i == 64) ? 33 : i + 1);
      check("c5_flag", out_reset_flag, (i == 64) ? 1 : 0);
      step();
    end
    check("hold_valid", out_valid, 0);
    check("hold_N", out_N, 64);
    check("hold_N_new", out_N_new, 33);
    check("hold_flag", out_reset_flag, 1);
    send(9'd5);
    check("c5_after_halve", out_N, 33);
    step();

    // Back-to-back ctx 7
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    in_valid = 1'b1;
    in_ctx   = 9'd7;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 2) in_valid = 1'b0;
      e = exp_q.pop_front();
      check("b2b_valid", out_valid, 1);
      check("b2b_N", out_N, e);
      check("b2b_N_new", out_N_new, e + 1);
    end
    step();
    check("b2b_done", out_valid, 0);

    // Out-of-range context
    send(9'd400);
    check("oor_valid", out_valid, 0);
    check("oor_err", err_ctx, 1);
    step();
    send(9'd2);
    check("c2_valid", out_valid, 1);
    check("c2_N", out_N, 1);
    check("err_sticky", err_ctx, 1);
    step();

    // Flush the cycle after accepting ctx 9; a simultaneous request is refused
    send(9'd9);
    in_valid = 1'b1;
    in_ctx   = 9'd9;
    flush    = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 0);
    check("fl_out_valid", out_valid, 1);
    check("fl_out_ctx", out_ctx, 9);
    check("fl_out_N", out_N, 1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_no_accept", out_valid, 0);
    check("fl_err_clr", err_ctx, 0);
    check("fl_init", init_done, 0);
    count_init(n);
    check("fl_init_len", n, 367);
    send(9'd9);
    check("fl_c9_N", out_N, 1);
    step();
    send(9'd5);
    check("fl_c5_N", out_N, 1);
    step();

    // Reset when the INIT counter reaches 200
    flush = 1'b1;
    step();
    flush = 1'b0;
    repeat (200) step();
    check("mid_init_busy", in_ready, 0);
    rst_n = 1'b0;
    step();
    check("mr_in_ready", in_ready, 0);
    check("mr_init_done", init_done, 0);
    check("mr_out_N", out_N, 0);
    rst_n = 1'b1;
    count_init(n);
    check("mr_init_len", n, 367);
    send(9'd7);
    check("mr_c7_valid", out_valid, 1);
    check("mr_c7_N", out_N, 1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
